// File: rtl/pin_entry_controller.sv
// Keypad PIN collector for the account authenticator; status sampled SETTLE_CYCLES after submit, result pulses one cycle later.
// Optional ENTRY_TIMEOUT_EN adds an inactivity timeout in ENTRY; no backpressure, strobes outside ENTRY are dropped.
module pin_entry_controller #(
   parameter int PIN_DIGITS     = 4,
   parameter int MAX_TRIES      = 3,
   parameter int SETTLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        card_inserted,
   input  logic [3:0]  card_acc_num,
   input  logic        digit_valid,
   input  logic [3:0]  digit,
   input  logic        clear,
   input  logic        enter,
   input  logic        acc_found_stat,
   input  logic        acc_auth_stat,
   output logic [3:0]  acc_num,
   output logic [15:0] pin,
   output logic [2:0]  digit_count,
   output logic [2:0]  attempts_left,
   output logic        busy,
   output logic        auth_ok,
   output logic        auth_fail,
   output logic        no_account,
   output logic        granted,
   output logic        locked,
   output logic        timeout
);

   typedef enum logic [2:0] {IDLE, ENTRY, CHECK, GRANTED, LOCKED} state_t;

   localparam int            SW        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES);
   localparam logic [2:0]    PIN_LEN   = 3'(PIN_DIGITS);
   localparam logic [2:0]    TRIES     = 3'(MAX_TRIES);

   state_t          state, state_nx;
   logic [3:0]      acc_nx;
   logic [15:0]     pin_nx;
   logic [2:0]      cnt_nx, att_nx;
   logic [SW-1:0]   settle, settle_nx;
   logic            ok_nx, fail_nx, noacc_nx;

`ifdef ENTRY_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tmo_cnt, tmo_cnt_nx;
   logic        tmo_nx, tmo_r;
`endif

   always_comb begin
      state_nx  = state;
      acc_nx    = acc_num;
      pin_nx    = pin;
      cnt_nx    = digit_count;
      att_nx    = attempts_left;
      settle_nx = settle;
      ok_nx     = 1'b0;
      fail_nx   = 1'b0;
      noacc_nx  = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
      tmo_cnt_nx = '0;
      tmo_nx     = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (card_inserted) begin
               state_nx = ENTRY;
               acc_nx   = card_acc_num;
               pin_nx   = '0;
               cnt_nx   = '0;
               att_nx   = TRIES;
            end
         end
         ENTRY: begin
            if (clear) begin
               pin_nx = '0;
               cnt_nx = '0;
            end else if (digit_valid) begin
               if (digit <= 4'd9 && digit_count < PIN_LEN) begin
                  pin_nx = pin * 16'd10 + {12'd0, digit};
                  cnt_nx = digit_count + 3'd1;
               end
            end else if (enter && digit_count == PIN_LEN) begin
               state_nx  = CHECK;
               settle_nx = SETTLE_LD;
            end
`ifdef ENTRY_TIMEOUT_EN
            // Any keypad strobe restarts the inactivity window.
            if (!(clear || digit_valid || enter)) begin
               if (tmo_cnt == TMO_LAST) begin
                  tmo_nx   = 1'b1;
                  state_nx = IDLE;
                  pin_nx   = '0;
                  cnt_nx   = '0;
                  acc_nx   = '0;
               end else begin
                  tmo_cnt_nx = tmo_cnt + 16'd1;
               end
            end
`endif
         end
         CHECK: begin
            // Final settle cycle: authenticator outputs are stable now.
            if (settle == SW'(1)) begin
               if (!acc_found_stat) begin
                  noacc_nx = 1'b1;
                  state_nx = LOCKED;
                  pin_nx   = '0;
               end else if (acc_auth_stat) begin
                  ok_nx    = 1'b1;
                  state_nx = GRANTED;
               end else begin
                  fail_nx = 1'b1;
                  att_nx  = attempts_left - 3'd1;
                  pin_nx  = '0;
                  cnt_nx  = '0;
                  state_nx = (attempts_left == 3'd1) ? LOCKED : ENTRY;
               end
            end else begin
               settle_nx = settle - SW'(1);
            end
         end
         LOCKED:  pin_nx = '0;
         default: ;
      endcase

      // Card removal overrides everything, including a same-cycle status sample.
      if (state != IDLE && !card_inserted) begin
         state_nx = IDLE;
         acc_nx   = '0;
         pin_nx   = '0;
         cnt_nx   = '0;
         ok_nx    = 1'b0;
         fail_nx  = 1'b0;
         noacc_nx = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
         tmo_nx     = 1'b0;
         tmo_cnt_nx = '0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         acc_num       <= '0;
         pin           <= '0;
         digit_count   <= '0;
         attempts_left <= TRIES;
         settle        <= '0;
         auth_ok       <= 1'b0;
         auth_fail     <= 1'b0;
         no_account    <= 1'b0;
      end else begin
         state         <= state_nx;
         acc_num       <= acc_nx;
         pin           <= pin_nx;
         digit_count   <= cnt_nx;
         attempts_left <= att_nx;
         settle        <= settle_nx;
         auth_ok       <= ok_nx;
         auth_fail     <= fail_nx;
         no_account    <= noacc_nx;
      end
   end

`ifdef ENTRY_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
         tmo_r   <= 1'b0;
      end else begin
         tmo_cnt <= tmo_cnt_nx;
         tmo_r   <= tmo_nx;
      end
   end
   assign timeout = tmo_r;
`else
   // Without the feature ENTRY waits forever; the parameter is kept for a uniform interface.
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

   assign busy    = (state == CHECK);
   assign granted = (state == GRANTED);
   assign locked  = (state == LOCKED);

endmodule

// File: tb/tb_pin_entry_controller.sv
// Directed bench for pin_entry_controller; outputs sampled 1ns after each rising edge.
module tb_pin_entry_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        card_inserted;
   logic [3:0]  card_acc_num;
   logic        digit_valid;
   logic [3:0]  digit;
   logic        clear;
   logic        enter;
   logic        acc_found_stat;
   logic        acc_auth_stat;
   logic [3:0]  acc_num;
   logic [15:0] pin;
   logic [2:0]  digit_count;
   logic [2:0]  attempts_left;
   logic        busy, auth_ok, auth_fail, no_account, granted, locked, timeout;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   pin_entry_controller #(
      .PIN_DIGITS(4), .MAX_TRIES(3), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(20)
   ) dut (
      .clk(clk), .rst(rst), .card_inserted(card_inserted), .card_acc_num(card_acc_num),
      .digit_valid(digit_valid), .digit(digit), .clear(clear), .enter(enter),
      .acc_found_stat(acc_found_stat), .acc_auth_stat(acc_auth_stat),
      .acc_num(acc_num), .pin(pin), .digit_count(digit_count), .attempts_left(attempts_left),
      .busy(busy), .auth_ok(auth_ok), .auth_fail(auth_fail), .no_account(no_account),
      .granted(granted), .locked(locked), .timeout(timeout)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic key(input logic [3:0] d);
      digit_valid = 1'b1;
      digit       = d;
      tick();
      digit_valid = 1'b0;
   endtask

   task automatic press_enter();
      enter = 1'b1;
      tick();
      enter = 1'b0;
   endtask

   task automatic press_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic insert(input logic [3:0] acc);
      card_inserted = 1'b1;
      card_acc_num  = acc;
      tick();
   endtask

   initial begin
      rst = 1'b1; card_inserted = 1'b0; card_acc_num = 4'd0;
      digit_valid = 1'b0; digit = 4'd0; clear = 1'b0; enter = 1'b0;
      acc_found_stat = 1'b0; acc_auth_stat = 1'b0;
      #12;
      // Reset values
      check("rst_acc", 16'(acc_num), 16'd0);
      check("rst_pin", pin, 16'd0);
      check("rst_cnt", 16'(digit_count), 16'd0);
      check("rst_att", 16'(attempts_left), 16'd3);
      check("rst_flags", 16'({busy, auth_ok, auth_fail, no_account, granted, locked, timeout}), 16'd0);
      rst = 1'b0;
      tick();

      // Successful authentication, acc 3, PIN 1234
      insert(4'd3);
      check("acc_latch", 16'(acc_num), 16'd3);
      key(4'd1); key(4'd2); key(4'd3); key(4'd4);
      check("pin_1234", pin, 16'h04D2);
      check("cnt_full", 16'(digit_count), 16'd4);
      acc_found_stat = 1'b1; acc_auth_stat = 1'b1;
      press_enter();
      check("busy_c1", 16'(busy), 16'd1);
      tick();
      check("busy_c2", 16'({busy, auth_ok}), 16'b10);
      tick();
      check("ok_pulse", 16'({busy, auth_ok, granted}), 16'b011);
      check("ok_att", 16'(attempts_left), 16'd3);
      check("ok_pin_held", pin, 16'd1234);
      tick();
      check("ok_one_cycle", 16'({auth_ok, granted}), 16'b01);

      // Three failures lead to lock
      card_inserted = 1'b0;
      tick();
      check("remove_acc", 16'(acc_num), 16'd0);
      check("remove_granted", 16'(granted), 16'd0);
      insert(4'd5);
      acc_found_stat = 1'b1; acc_auth_stat = 1'b0;
      for (int i = 0; i < 3; i++) begin
         key(4'd5); key(4'd6); key(4'd7); key(4'd8);
         check("pin_5678", pin, 16'd5678);
         press_enter();
         tick();
         tick();
         check("fail_pulse", 16'({auth_fail, auth_ok, no_account}), 16'b100);
         check("fail_att", 16'(attempts_left), 16'(2 - i));
         check("fail_lock", 16'(locked), (i == 2) ? 16'd1 : 16'd0);
         check("fail_pin_clr", pin, 16'd0);
      end
      key(4'd1);
      check("lock_key_ign", 16'({digit_count, pin}), 16'd0);

      // Clear, ignored short enter, ignored digit >9, then no account
      card_inserted = 1'b0;
      tick();
      insert(4'd7);
      key(4'd1); key(4'd2);
      check("cnt_2", 16'(digit_count), 16'd2);
      press_clear();
      check("clear", 16'({digit_count, pin}), 16'd0);
      key(4'd9); key(4'd0); key(4'd0);
      press_enter();
      check("short_enter", 16'({busy, digit_count}), 16'd3);
      key(4'hC);
      check("big_digit", 16'(digit_count), 16'd3);
      clear = 1'b1; digit_valid = 1'b1; digit = 4'd5;
      tick();
      clear = 1'b0; digit_valid = 1'b0;
      check("clear_prio", 16'({digit_count, pin}), 16'd0);
      key(4'd9); key(4'd0); key(4'd0); key(4'd1);
      check("pin_9001", pin, 16'h2329);
      acc_found_stat = 1'b0; acc_auth_stat = 1'b0;
      press_enter();
      tick();
      tick();
      check("noacc", 16'({no_account, auth_fail, locked}), 16'b101);
      check("noacc_att", 16'(attempts_left), 16'd3);

      // Card dropped on the status-sample cycle
      card_inserted = 1'b0;
      tick();
      insert(4'd9);
      key(4'd1); key(4'd1); key(4'd1); key(4'd1);
      acc_found_stat = 1'b1; acc_auth_stat = 1'b1;
      press_enter();
      tick();
      card_inserted = 1'b0;
      tick();
      check("drop_flags", 16'({busy, auth_ok, auth_fail, no_account, granted, locked}), 16'd0);
      check("drop_acc", 16'(acc_num), 16'd0);
      check("drop_pin", pin, 16'd0);
      tick();
      check("drop_no_late", 16'({auth_ok, granted}), 16'd0);

      // Asynchronous reset mid-ENTRY
      insert(4'd6);
      key(4'd2); key(4'd3);
      check("pre_rst_cnt", 16'(digit_count), 16'd2);
      rst = 1'b1;
      #2;
      check("arst_acc", 16'(acc_num), 16'd0);
      check("arst_cnt", 16'({digit_count, pin}), 16'd0);
      check("arst_att", 16'(attempts_left), 16'd3);
      rst = 1'b0;
      tick();

`ifdef ENTRY_TIMEOUT_EN
      // One failure, then inactivity timeout; re-entry restores attempts
      acc_found_stat = 1'b1; acc_auth_stat = 1'b0;
      key(4'd4); key(4'd4); key(4'd4); key(4'd4);
      press_enter();
      tick();
      tick();
      check("tmo_pre_att", 16'(attempts_left), 16'd2);
      key(4'd1); key(4'd2);
      repeat (19) tick();
      check("tmo_not_yet", 16'({timeout, digit_count}), 16'd2);
      tick();
      check("tmo_pulse", 16'(timeout), 16'd1);
      check("tmo_clr", 16'({acc_num, digit_count}), 16'd0);
      tick();
      check("tmo_one_cycle", 16'(timeout), 16'd0);
      check("tmo_reentry_att", 16'(attempts_left), 16'd3);
      check("tmo_reentry_acc", 16'(acc_num), 16'd6);
`else
      key(4'd1); key(4'd2);
      repeat (30) tick();
      check("no_tmo_wait", 16'({timeout, digit_count}), 16'd2);
      check("no_tmo_acc", 16'(acc_num), 16'd6);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
